// File: rtl/puf_crp_engine.sv
// rtl/puf_crp_engine.sv - challenge/response controller between a UART byte pair and an arbiter PUF
// Gray-codes the assembled challenge, majority-votes NVOTE PUF runs and streams the result as bytes.
module puf_crp_engine #(
  parameter int CW = 16,
  parameter int RW = 16,
  parameter int SETTLE = 8,
  parameter int NVOTE = 1,
  parameter logic [RW-1:0] CHK_PAT = RW'(16'hABCD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          check,
  output logic [CW-1:0] puf_challenge,
  output logic          puf_trigger,
  input  logic [RW-1:0] puf_response,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  localparam int NCB  = CW / 8;
  localparam int NRB  = RW / 8;
  localparam int CNTW = $clog2(NVOTE + 1);
  localparam int BCW  = $clog2(NCB + 1);
  localparam int TBW  = $clog2(NRB + 1);
  localparam int SCW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_RX    = 3'd0,
    S_APPLY = 3'd1,
    S_FIRE  = 3'd2,
    S_VOTE  = 3'd3,
    S_TX    = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            buf_q, buf_d;
  logic [BCW-1:0]           rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]            chal_q, chal_d;
  logic                     check_q, check_d;
  logic [SCW-1:0]           fire_q, fire_d;
  logic [CNTW-1:0]          eval_q, eval_d;
  logic [RW-1:0][CNTW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]            word_q, word_d;
  logic [TBW-1:0]           tx_cnt_q, tx_cnt_d;
  logic                     tx_valid_q, tx_valid_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     done_q, done_d;
  logic                     overrun_q, overrun_d;

  logic [CW-1:0]            assembled;
  logic [RW-1:0]            word_shl;
  logic [RW-1:0]            vote_res;

  // New byte enters at the LSB end so the first byte received ends up most significant.
  assign assembled = CW'({buf_q, rx_data});
  assign word_shl  = word_q << 8;

  always_comb begin
    vote_res = '0;
    for (int i = 0; i < RW; i++) begin
      vote_res[i] = (cnt_q[i] > CNTW'(NVOTE / 2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RX;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    rx_cnt_d   = rx_cnt_q;
    chal_d     = chal_q;
    check_d    = check_q;
    fire_d     = fire_q;
    eval_d     = eval_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    tx_cnt_d   = tx_cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q;

    if (rx_valid && (state_q != S_RX)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_RX: begin
        if (rx_valid) begin
          if (rx_cnt_q == BCW'(NCB - 1)) begin
            chal_d   = assembled ^ (assembled >> 1);
            check_d  = check;
            cnt_d    = '0;
            eval_d   = '0;
            fire_d   = '0;
            buf_d    = '0;
            rx_cnt_d = '0;
            state_d  = S_APPLY;
          end else begin
            buf_d    = assembled;
            rx_cnt_d = rx_cnt_q + BCW'(1);
          end
        end
      end
      S_APPLY: begin
        state_d = S_FIRE;
      end
      S_FIRE: begin
        if (fire_q == SCW'(SETTLE - 1)) begin
          fire_d = '0;
          for (int i = 0; i < RW; i++) begin
            if (puf_response[i]) begin
              cnt_d[i] = cnt_q[i] + CNTW'(1);
            end
          end
          eval_d  = eval_q + CNTW'(1);
          state_d = (eval_q == CNTW'(NVOTE - 1)) ? S_VOTE : S_APPLY;
        end else begin
          fire_d = fire_q + SCW'(1);
        end
      end
      S_VOTE: begin
        word_d   = check_q ? CHK_PAT : vote_res;
        tx_cnt_d = '0;
        state_d  = S_TX;
      end
      S_TX: begin
        // First TX cycle only loads the output register; bytes advance on the handshake after that.
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = word_q[RW-1 -: 8];
        end else if (tx_ready) begin
          if (tx_cnt_q == TBW'(NRB - 1)) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            done_d     = 1'b1;
            rx_cnt_d   = '0;
            state_d    = S_RX;
          end else begin
            tx_cnt_d  = tx_cnt_q + TBW'(1);
            word_d    = word_shl;
            tx_data_d = word_shl[RW-1 -: 8];
          end
        end
      end
      default: begin
        state_d = S_RX;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      rx_cnt_q   <= '0;
      chal_q     <= '0;
      check_q    <= 1'b0;
      fire_q     <= '0;
      eval_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      tx_cnt_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      rx_cnt_q   <= rx_cnt_d;
      chal_q     <= chal_d;
      check_q    <= check_d;
      fire_q     <= fire_d;
      eval_q     <= eval_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign puf_challenge = chal_q;
  assign puf_trigger   = (state_q == S_FIRE);
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign busy          = (state_q != S_RX);
  assign done          = done_q;
  assign overrun       = overrun_q;

endmodule
